// File: rtl/merge_3.sv
// Three-channel 4-phase join that restores program order using an order FIFO
// filled by the split side; only the channel at the FIFO head is served.
module merge_3 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ord_push,
  input  logic [1:0]               ord_sel,
  input  logic                     req_in_1,
  input  logic                     req_in_2,
  input  logic                     req_in_3,
  input  logic [WIDTH-1:0]         data_in_1,
  input  logic [WIDTH-1:0]         data_in_2,
  input  logic [WIDTH-1:0]         data_in_3,
  input  logic                     ack_in,
  output logic                     ack_out_1,
  output logic                     ack_out_2,
  output logic                     ack_out_3,
  output logic                     req_out,
  output logic [WIDTH-1:0]         data_out,
  output logic [1:0]               sel_out,
  output logic [$clog2(DEPTH):0]   ord_count,
  output logic                     ord_ovf,
  output logic                     ord_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: each channel holds req high with stable data until its ack rises,
  // then drops req; ack falls only once both req_in_k and ack_in are low.
  typedef enum logic [1:0] {IDLE, FWD, RTZ} state_t;

  state_t            state_q, state_d;
  logic              req_out_q, req_out_d;
  logic [2:0]        ack_q, ack_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        mem_q [DEPTH];
  logic [1:0]        mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic [1:0]        head_sel;
  logic              head_req;
  logic [WIDTH-1:0]  head_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push_ok;
  logic [3:0]        req_vec;

  assign req_vec    = {1'b0, req_in_3, req_in_2, req_in_1};
  assign head_sel   = mem_q[rd_ptr_q];
  assign head_req   = req_vec[head_sel];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));

  always_comb begin
    head_data = data_in_1;
    case (head_sel)
      2'd1:    head_data = data_in_2;
      2'd2:    head_data = data_in_3;
      default: head_data = data_in_1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_out_d = req_out_q;
    ack_d     = ack_q;
    data_d    = data_q;
    sel_d     = sel_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && head_req) begin
          data_d    = head_data;
          sel_d     = head_sel;
          req_out_d = 1'b1;
          state_d   = FWD;
        end
      end
      FWD: begin
        if (ack_in) begin
          req_out_d = 1'b0;
          ack_d     = 3'(3'b001 << head_sel);
          state_d   = RTZ;
        end
      end
      RTZ: begin
        if (!head_req && !ack_in) begin
          ack_d   = 3'b000;
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A push at full still lands when the same cycle pops, since a slot frees up.
  always_comb begin
    push_ok = 1'b0;
    ovf_d   = ovf_q;
    err_d   = err_q;
    mem_d   = mem_q;
    if (ord_push) begin
      if (ord_sel == 2'd3) begin
        err_d = 1'b1;
      end else if (!fifo_full || pop) begin
        push_ok = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (push_ok) mem_d[wr_ptr_q] = ord_sel;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_out_q <= 1'b0;
      ack_q     <= 3'b000;
      data_q    <= '0;
      sel_q     <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_out_q <= req_out_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign ack_out_1 = ack_q[0];
  assign ack_out_2 = ack_q[1];
  assign ack_out_3 = ack_q[2];
  assign req_out   = req_out_q;
  assign data_out  = data_q;
  assign sel_out   = sel_q;
  assign ord_count = count_q;
  assign ord_ovf   = ovf_q;
  assign ord_err   = err_q;

endmodule

// File: tb/tb_merge_3.sv
// Bench for merge_3: directed handshake/FIFO scenarios, then randomized
// upstream/downstream agents checked against a queue-based ordering model.
module tb_merge_3;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              ord_push = 1'b0;
  logic [1:0]        ord_sel = 2'd0;
  logic [2:0]        req_in = 3'b000;
  logic [WIDTH-1:0]  data_in [3];
  logic              ack_in = 1'b0;
  logic [2:0]        ack_out;
  logic              req_out;
  logic [WIDTH-1:0]  data_out;
  logic [1:0]        sel_out;
  logic [CW-1:0]     ord_count;
  logic              ord_ovf;
  logic              ord_err;

  merge_3 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ord_push  (ord_push),
    .ord_sel   (ord_sel),
    .req_in_1  (req_in[0]),
    .req_in_2  (req_in[1]),
    .req_in_3  (req_in[2]),
    .data_in_1 (data_in[0]),
    .data_in_2 (data_in[1]),
    .data_in_3 (data_in[2]),
    .ack_in    (ack_in),
    .ack_out_1 (ack_out[0]),
    .ack_out_2 (ack_out[1]),
    .ack_out_3 (ack_out[2]),
    .req_out   (req_out),
    .data_out  (data_out),
    .sel_out   (sel_out),
    .ord_count (ord_count),
    .ord_ovf   (ord_ovf),
    .ord_err   (ord_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; ord_push = 1'b0; ord_sel = 2'd0; req_in = 3'b000; ack_in = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // scoreboard: expected merged tokens {sel, data} in program order
  logic [WIDTH+1:0] exp_q [$];
  logic [WIDTH-1:0] up_q [3][$];
  int   m_cnt;
  bit   m_err, pend_push, pend_err, prev_req;
  logic [2:0] prev_ack;
  logic [WIDTH-1:0] prev_data;
  int   n_tokens;

  task automatic agent_cycle(input bit allow_push);
    logic [WIDTH+1:0] e;
    logic [WIDTH-1:0] d;
    int s;
    // sample and check
    if (pend_push) m_cnt++;
    if (pend_err) m_err = 1'b1;
    pend_push = 1'b0;
    pend_err  = 1'b0;
    for (int c = 0; c < 3; c++) if (prev_ack[c] && !ack_out[c]) m_cnt--;
    check_eq("ack_onehot", 64'($countones(ack_out) <= 1), 64'd1);
    check_eq("rnd_count", 64'(ord_count), 64'(m_cnt));
    check_eq("rnd_err", 64'(ord_err), 64'(m_err));
    check_eq("rnd_ovf", 64'(ord_ovf), 64'd0);
    if (req_out && !prev_req) begin
      check_eq("tok_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("tok_data", 64'(data_out), 64'(e[WIDTH-1:0]));
        check_eq("tok_sel", 64'(sel_out), 64'(e[WIDTH+1:WIDTH]));
        n_tokens++;
      end
    end else if (req_out && prev_req) begin
      check_eq("data_hold", 64'(data_out), 64'(prev_data));
    end
    prev_req  = req_out;
    prev_ack  = ack_out;
    prev_data = data_out;
    // drive order FIFO
    ord_push = 1'b0;
    ord_sel  = 2'd0;
    if (allow_push && m_cnt < DEPTH && $urandom_range(0, 2) == 0) begin
      ord_push = 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        ord_sel  = 2'd3;
        pend_err = 1'b1;
      end else begin
        s = $urandom_range(0, 2);
        d = $urandom;
        ord_sel = 2'(s);
        up_q[s].push_back(d);
        exp_q.push_back({2'(s), d});
        pend_push = 1'b1;
      end
    end
    // upstream channels
    for (int c = 0; c < 3; c++) begin
      if (!req_in[c] && !ack_out[c]) begin
        if (up_q[c].size() > 0 && $urandom_range(0, 1) == 1) begin
          req_in[c]  = 1'b1;
          data_in[c] = up_q[c][0];
        end else begin
          data_in[c] = $urandom;
        end
      end else if (req_in[c] && ack_out[c] && $urandom_range(0, 1) == 1) begin
        req_in[c] = 1'b0;
        void'(up_q[c].pop_front());
      end
    end
    // downstream
    if (req_out && !ack_in && $urandom_range(0, 1) == 1) ack_in = 1'b1;
    else if (!req_out && ack_in && $urandom_range(0, 1) == 1) ack_in = 1'b0;
    tick();
  endtask

  initial begin
    int budget;
    for (int c = 0; c < 3; c++) data_in[c] = '0;

    // 1: reset with requests pending
    rst_n = 1'b0; req_in = 3'b111;
    tick(); tick();
    check_eq("rst_req_out", 64'(req_out), 64'd0);
    check_eq("rst_ack", 64'(ack_out), 64'd0);
    check_eq("rst_data", 64'(data_out), 64'd0);
    check_eq("rst_sel", 64'(sel_out), 64'd0);
    check_eq("rst_count", 64'(ord_count), 64'd0);
    check_eq("rst_flags", 64'({ord_ovf, ord_err}), 64'd0);

    // 2: single token on ch3
    reset_dut();
    ord_push = 1'b1; ord_sel = 2'd2; req_in[2] = 1'b1; data_in[2] = 32'hDEADBEEF;
    tick();
    ord_push = 1'b0;
    check_eq("t2_not_yet", 64'(req_out), 64'd0);
    tick();
    check_eq("t2_req_out", 64'(req_out), 64'd1);
    check_eq("t2_data", 64'(data_out), 64'hDEADBEEF);
    check_eq("t2_sel", 64'(sel_out), 64'd2);
    ack_in = 1'b1; tick();
    check_eq("t2_ack3", 64'(ack_out), 64'b100);
    check_eq("t2_req_low", 64'(req_out), 64'd0);
    req_in[2] = 1'b0; ack_in = 1'b0; tick();
    check_eq("t2_ack_rtz", 64'(ack_out), 64'd0);
    check_eq("t2_count", 64'(ord_count), 64'd0);

    // 3: program order beats arrival order
    reset_dut();
    ord_push = 1'b1; ord_sel = 2'd1;
    req_in[0] = 1'b1; data_in[0] = 32'h1111_0001;
    req_in[1] = 1'b1; data_in[1] = 32'h2222_0002;
    tick();
    ord_sel = 2'd0; tick();
    ord_push = 1'b0;
    check_eq("t3_req1", 64'(req_out), 64'd1);
    check_eq("t3_sel1", 64'(sel_out), 64'd1);
    check_eq("t3_data1", 64'(data_out), 64'h2222_0002);
    ack_in = 1'b1; tick();
    check_eq("t3_ack2_only", 64'(ack_out), 64'b010);
    req_in[1] = 1'b0; ack_in = 1'b0; tick();
    check_eq("t3_pop_ack", 64'(ack_out), 64'd0);
    check_eq("t3_pop_count", 64'(ord_count), 64'd1);
    check_eq("t3_idle_req", 64'(req_out), 64'd0);
    tick();
    check_eq("t3_req2", 64'(req_out), 64'd1);
    check_eq("t3_sel2", 64'(sel_out), 64'd0);
    check_eq("t3_data2", 64'(data_out), 64'h1111_0001);
    ack_in = 1'b1; tick();
    check_eq("t3_ack1", 64'(ack_out), 64'b001);
    req_in[0] = 1'b0; ack_in = 1'b0; tick();
    check_eq("t3_count_end", 64'(ord_count), 64'd0);

    // 4: fill, push+pop at full, then overflow
    reset_dut();
    for (int i = 0; i < DEPTH; i++) begin
      ord_push = 1'b1; ord_sel = 2'd0; tick();
    end
    ord_push = 1'b0;
    check_eq("t4_full", 64'(ord_count), 64'(DEPTH));
    check_eq("t4_no_ovf", 64'(ord_ovf), 64'd0);
    req_in[0] = 1'b1; data_in[0] = 32'hA5A5_0004; tick();
    ack_in = 1'b1; tick();
    req_in[0] = 1'b0; ack_in = 1'b0; ord_push = 1'b1; ord_sel = 2'd1; tick();
    ord_push = 1'b0;
    check_eq("t4_pushpop_count", 64'(ord_count), 64'(DEPTH));
    check_eq("t4_pushpop_ovf", 64'(ord_ovf), 64'd0);
    ord_push = 1'b1; ord_sel = 2'd2; tick();
    ord_push = 1'b0;
    check_eq("t4_ovf_count", 64'(ord_count), 64'(DEPTH));
    check_eq("t4_ovf", 64'(ord_ovf), 64'd1);

    // 5: illegal selector
    ord_push = 1'b1; ord_sel = 2'd3; tick();
    ord_push = 1'b0; tick();
    check_eq("t5_err", 64'(ord_err), 64'd1);
    check_eq("t5_count", 64'(ord_count), 64'(DEPTH));
    check_eq("t5_ovf_sticky", 64'(ord_ovf), 64'd1);

    // 6: reset while forwarding
    reset_dut();
    ord_push = 1'b1; ord_sel = 2'd1; req_in[1] = 1'b1; data_in[1] = 32'h0BAD_F00D; tick();
    ord_push = 1'b0; tick();
    check_eq("t6_fwd", 64'(req_out), 64'd1);
    rst_n = 1'b0; tick();
    check_eq("t6_rst_req", 64'(req_out), 64'd0);
    check_eq("t6_rst_count", 64'(ord_count), 64'd0);
    rst_n = 1'b1; req_in[1] = 1'b0;
    ord_push = 1'b1; ord_sel = 2'd0; req_in[0] = 1'b1; data_in[0] = 32'h600D_0006; tick();
    ord_push = 1'b0; tick();
    check_eq("t6_new_req", 64'(req_out), 64'd1);
    check_eq("t6_new_data", 64'(data_out), 64'h600D_0006);
    check_eq("t6_new_sel", 64'(sel_out), 64'd0);
    ack_in = 1'b1; tick();
    check_eq("t6_new_ack", 64'(ack_out), 64'b001);
    req_in[0] = 1'b0; ack_in = 1'b0; tick();
    check_eq("t6_new_count", 64'(ord_count), 64'd0);

    // randomized traffic
    reset_dut();
    m_cnt = 0; m_err = 1'b0; pend_push = 1'b0; pend_err = 1'b0;
    prev_req = 1'b0; prev_ack = 3'b000; prev_data = '0; n_tokens = 0;
    for (int i = 0; i < 3000; i++) agent_cycle(1'b1);
    budget = 0;
    while (budget < 500 && (exp_q.size() > 0 || req_in != 3'b000 || ack_in || req_out
                            || ack_out != 3'b000 || pend_push)) begin
      agent_cycle(1'b0);
      budget++;
    end
    check_eq("drain_timeout", 64'(budget < 500), 64'd1);
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    check_eq("drain_count", 64'(ord_count), 64'd0);
    check_eq("tokens_seen", 64'(n_tokens > 50), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
